// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises I-fetch and D load/store requests onto one memory port
module mem_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [15:0]       tie_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic              owner_q, owner_d;
  logic [15:0]       tie_q, tie_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_wins;
  // D wins alone, or on a tie when fixed-priority or I held the port last
  assign d_wins = d_req & (~i_req | (D_PRIORITY != 0) | ~owner_q);
  // next-state: grant in IDLE, count out the memory latency, one ack cycle in RESP
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    tie_d       = tie_q;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d     = ACCESS;
        owner_d     = d_wins;
        mem_en_d    = 1'b1;
        mem_rw_d    = d_wins & d_we;
        mem_addr_d  = d_wins ? d_addr : i_addr;
        mem_wdata_d = d_wins ? d_wdata : '0;
        lat_d       = 4'(MEM_LAT - 1);
        tie_d       = (i_req & d_req & (tie_q != 16'hFFFF)) ? tie_q + 16'd1 : tie_q;
      end
      ACCESS: if (lat_q == 4'd0) begin
        state_d   = RESP;
        mem_en_d  = 1'b0;
        mem_rw_d  = 1'b0;
        i_ack_d   = ~owner_q;
        d_ack_d   = owner_q;
        i_rdata_d = owner_q ? i_rdata_q : mem_rdata;
        d_rdata_d = owner_q ? (mem_rw_q ? '0 : mem_rdata) : d_rdata_q;
      end else begin
        lat_d = lat_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any in-flight access without an ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      owner_q     <= 1'b0;
      tie_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      owner_q     <= owner_d;
      tie_q       <= tie_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign owner     = owner_q;
  assign tie_cnt   = tie_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: three arbiter configurations checked against a transaction-phase model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_n = 3'b000, i_req = 3'b000, d_req = 3'b000, d_we = 3'b000;
  logic [63:0] i_addr [3], d_addr [3], d_wdata [3], mem_rdata [3];
  logic [2:0] i_ack, d_ack, mem_en, mem_rw, busy, owner;
  logic [63:0] i_rdata [3], d_rdata [3], mem_addr [3], mem_wdata [3];
  logic [15:0] tie_cnt [3];
  int checks = 0, failures = 0;
  // instance 0: MEM_LAT=1 round-robin, 1: MEM_LAT=3 round-robin, 2: MEM_LAT=4 D priority
  for (genvar g = 0; g < 3; g++) begin : gi
    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(g == 0 ? 1 : g == 1 ? 3 : 4),
                      .D_PRIORITY(g == 2 ? 1 : 0)) u (
      .clk(clk), .reset(rst_n[g]),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g]), .tie_cnt(tie_cnt[g]));
  end
  function automatic int lat(int k);
    return k == 0 ? 1 : k == 1 ? 3 : 4;
  endfunction
  // model: ph counts cycles since the grant edge (0 = idle); memory phase 1..LAT, ack at LAT+1
  int ph [3];
  bit m_own [3], m_we [3];
  logic [63:0] m_addr [3], m_wdata [3], m_ird [3], m_drd [3];
  logic [15:0] m_tie [3];
  function automatic bit win(int k);
    return d_req[k] & (!i_req[k] | (k == 2) | !m_own[k]);
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        ph[k] <= 0; m_own[k] <= 0; m_we[k] <= 0; m_addr[k] <= 0; m_wdata[k] <= 0;
        m_ird[k] <= 0; m_drd[k] <= 0; m_tie[k] <= 0;
      end else if (ph[k] == 0) begin
        if (i_req[k] | d_req[k]) begin
          ph[k] <= 1;
          m_own[k] <= win(k);
          m_we[k] <= win(k) & d_we[k];
          m_addr[k] <= win(k) ? d_addr[k] : i_addr[k];
          m_wdata[k] <= win(k) ? d_wdata[k] : 64'd0;
          if (i_req[k] & d_req[k] & (m_tie[k] != 16'hFFFF)) m_tie[k] <= m_tie[k] + 1;
        end
      end else begin
        ph[k] <= (ph[k] == lat(k) + 1) ? 0 : ph[k] + 1;
        if (ph[k] == lat(k)) begin
          if (m_own[k]) m_drd[k] <= m_we[k] ? 64'd0 : mem_rdata[k];
          else m_ird[k] <= mem_rdata[k];
        end
      end
    end
  end
  function automatic logic [277:0] exp_v(int k);
    bit en, ak;
    en = ph[k] >= 1 && ph[k] <= lat(k);
    ak = ph[k] == lat(k) + 1;
    return {ph[k] != 0, en, en & m_we[k], ak & !m_own[k], ak & m_own[k], m_own[k], m_tie[k],
            m_addr[k], m_wdata[k], m_ird[k], m_drd[k]};
  endfunction
  function automatic logic [277:0] act_v(int k);
    return {busy[k], mem_en[k], mem_rw[k], i_ack[k], d_ack[k], owner[k], tie_cnt[k],
            mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k]};
  endfunction
  // every stimulus step advances to the falling edge and compares all instances with the model
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_v(k) !== exp_v(k)) begin
        failures++;
        $display("FAIL model_cmp inst=%0d t=%0t got=%h exp=%h", k, $time, act_v(k), exp_v(k));
      end
    end
  endtask
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic wait_ack(input int k, output int n, output bit who);
    n = 0;
    who = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (i_ack[k] | d_ack[k]) begin
        who = d_ack[k];
        return;
      end
    end
    checks++;
    failures++;
    n = -1;
    $display("FAIL ack_timeout inst=%0d got=none exp=ack", k);
  endtask
  initial begin
    int n, rwc;
    bit who, got;
    bit [3:0] order;
    for (int k = 0; k < 3; k++) begin
      i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; mem_rdata[k] = 64'h1111;
    end
    // T1 reset held with both requests high
    i_req = 3'b111; d_req = 3'b111;
    repeat (3) tick();
    for (int k = 0; k < 3; k++)
      chk("t1_quiet", {i_ack[k], d_ack[k], mem_en[k], mem_rw[k], busy[k], owner[k], tie_cnt[k]}, 0);
    i_req = 0; d_req = 0; rst_n = 3'b111;
    tick();
    // T2 single fetch, MEM_LAT=1
    i_addr[0] = 64'h40; mem_rdata[0] = 64'hDEADBEEF_00000013; i_req[0] = 1;
    tick();
    chk("t2_en", mem_en[0], 1);
    chk("t2_addr", mem_addr[0], 64'h40);
    chk("t2_rw", mem_rw[0], 0);
    tick();
    chk("t2_ack", {i_ack[0], d_ack[0], mem_en[0]}, 3'b100);
    chk("t2_rdata", i_rdata[0], 64'hDEADBEEF_00000013);
    i_req[0] = 0;
    repeat (2) tick();
    // T3 store, MEM_LAT=3; wdata changes after the grant
    d_addr[1] = 64'h100; d_wdata[1] = 64'h55; d_we[1] = 1; mem_rdata[1] = 64'h1234_5678; d_req[1] = 1;
    n = 0; rwc = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      n++;
      d_wdata[1] = 64'hAA;
      if (mem_rw[1] && mem_wdata[1] == 64'h55 && mem_addr[1] == 64'h100) rwc++;
      if (d_ack[1]) got = 1;
    end
    chk("t3_ack_seen", got, 1);
    chk("t3_ack_latency", n, 4);
    chk("t3_rw_cycles", rwc, 3);
    chk("t3_rdata", d_rdata[1], 0);
    d_req[1] = 0; d_we[1] = 0;
    repeat (2) tick();
    // T4 continuous tie, round-robin
    i_addr[0] = 64'h80; d_addr[0] = 64'h90; mem_rdata[0] = 64'h77; i_req[0] = 1; d_req[0] = 1;
    order = 0;
    for (int t = 0; t < 4; t++) begin
      wait_ack(0, n, who);
      order = {order[2:0], who};
      if (t == 3) begin i_req[0] = 0; d_req[0] = 0; end
    end
    chk("t4_order", order, 4'b1010);
    repeat (2) tick();
    chk("t4_tie", tie_cnt[0], 4);
    // T5 D priority: D thrice, I only after d_req drops
    i_addr[2] = 64'h10; d_addr[2] = 64'h20; mem_rdata[2] = 64'h99; i_req[2] = 1; d_req[2] = 1;
    order = 0;
    for (int t = 0; t < 4; t++) begin
      wait_ack(2, n, who);
      order = {order[2:0], who};
      if (t == 2) d_req[2] = 0;
      if (t == 3) i_req[2] = 0;
    end
    chk("t5_order", order, 4'b1110);
    repeat (2) tick();
    chk("t5_tie", tie_cnt[2], 3);
    // T6 reset in the 2nd ACCESS cycle, MEM_LAT=4
    i_addr[2] = 64'h200; i_req[2] = 1;
    repeat (2) tick();
    rst_n[2] = 0; i_req[2] = 0;
    tick();
    chk("t6_abort", {mem_en[2], busy[2], i_ack[2], d_ack[2], tie_cnt[2]}, 0);
    rst_n[2] = 1;
    rwc = 0;
    repeat (6) begin
      tick();
      if (i_ack[2] | d_ack[2]) rwc++;
    end
    chk("t6_no_ack", rwc, 0);
    i_addr[2] = 64'h300; mem_rdata[2] = 64'hCAFE; i_req[2] = 1;
    wait_ack(2, n, who);
    i_req[2] = 0;
    chk("t6_latency", n, 5);
    chk("t6_who", who, 0);
    chk("t6_rdata", i_rdata[2], 64'hCAFE);
    chk("t6_addr", mem_addr[2], 64'h300);
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
